// File: rtl/program_counter_register.sv
// program_counter_register
// Architectural PC for the single-cycle 32-bit core. Selects the next fetch
// address from PC+4, branch, jump or jump-register targets, traps misaligned
// targets to EXC_VECTOR, sequences BOOT/RUN/HALT and counts retired
// instructions. Every output comes from a register, so no input reaches an
// output combinationally.
module program_counter_register #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  input  logic        i_stall,
  input  logic        i_halt,
  output logic [31:0] o_pc,
  output logic        o_pc_valid,
  output logic        o_halted,
  output logic        o_misalign_exc,
  output logic [31:0] o_retired_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pcState_t;

  pcState_t    r_state;
  pcState_t    w_next_state;

  logic [31:0] r_pc;
  logic        r_pc_valid;
  logic        r_halted;
  logic        r_misalign_exc;
  logic [31:0] r_retired_count;

  logic [31:0] w_next_pc;
  logic        w_trap;
  logic        w_advance;
  logic [31:0] w_jump_target;
  logic        w_jr_misaligned;
  logic        w_branch_misaligned;

  // Jump targets keep the top nibble of PC+4 and are word aligned by construction.
  assign w_jump_target       = {i_pc_plus4[31:28], i_jump_index, 2'b00};
  assign w_jr_misaligned     = (i_jr_target[1:0] != 2'b00);
  assign w_branch_misaligned = (i_branch_target[1:0] != 2'b00);

  // State register; reset takes effect immediately and restarts in BOOT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and next-PC selection: halt > stall > jr > jump > branch > sequential.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_trap       = 1'b0;
    w_advance    = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_next_state = RUN;
      end
      RUN: begin
        if (i_halt) begin
          w_next_state = HALT;
        end else if (i_stall) begin
          w_next_pc = r_pc;
        end else if (i_jr) begin
          w_advance = 1'b1;
          if (w_jr_misaligned) begin
            w_next_pc = EXC_VECTOR;
            w_trap    = 1'b1;
          end else begin
            w_next_pc = i_jr_target;
          end
        end else if (i_jump) begin
          w_advance = 1'b1;
          w_next_pc = w_jump_target;
        end else if (i_branch_taken) begin
          w_advance = 1'b1;
          if (w_branch_misaligned) begin
            w_next_pc = EXC_VECTOR;
            w_trap    = 1'b1;
          end else begin
            w_next_pc = i_branch_target;
          end
        end else begin
          w_advance = 1'b1;
          w_next_pc = i_pc_plus4;
        end
      end
      HALT: begin
        w_next_state = HALT;
      end
      default: begin
        w_next_state = BOOT;
      end
    endcase
  end

  // PC register; holds in BOOT, HALT and on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Status flags are registered from the state being entered so they line up with the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_valid     <= 1'b0;
      r_halted       <= 1'b0;
      r_misalign_exc <= 1'b0;
    end else begin
      r_pc_valid     <= (w_next_state == RUN);
      r_halted       <= (w_next_state == HALT);
      r_misalign_exc <= w_trap;
    end
  end

  // Retired-instruction counter; traps count as retirements and the count wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_count <= 32'h0000_0000;
    end else if (w_advance) begin
      r_retired_count <= r_retired_count + 32'h0000_0001;
    end
  end

  assign o_pc            = r_pc;
  assign o_pc_valid      = r_pc_valid;
  assign o_halted        = r_halted;
  assign o_misalign_exc  = r_misalign_exc;
  assign o_retired_count = r_retired_count;

endmodule
